// File: rtl/bilbo_bist.sv
// BILBO register (shift / PRPG / normal / MISR) with a self-test session controller.
// Optional macro BILBO_LOCKUP_GUARD_EN: a PRPG step from the all-zero state reloads SEED.
module bilbo_bist #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
    parameter logic [WIDTH-1:0] SEED  = 8'h01,
    parameter int               CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             CE,
    input  logic             B1,
    input  logic             B2,
    input  logic             Si,
    output logic             So,
    input  logic [WIDTH-1:0] Z,
    output logic [WIDTH-1:0] Q,
    input  logic             Start,
    input  logic [CNT_W-1:0] NumPat,
    input  logic [WIDTH-1:0] ExpSig,
    output logic             Busy,
    output logic             Done,
    output logic             Pass
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       mode_l, mode_l_n, step_mode;
    logic [WIDTH-1:0] q_n, q_step;
    logic             fb, done_n, pass_n;

    assign fb = ^(Q & TAPS);
    assign So = Q[0];

    // A running session ignores the live mode pins and uses the mode latched at Start.
    assign step_mode = (state == S_RUN) ? mode_l : {B1, B2};

    always_comb begin
        case (step_mode)
            2'b00:   q_step = {Si, Q[WIDTH-1:1]};
            2'b01: begin
                q_step = {fb, Q[WIDTH-1:1]};
`ifdef BILBO_LOCKUP_GUARD_EN
                if (Q == '0) q_step = SEED;
`endif
            end
            2'b10:   q_step = Z;
            default: q_step = Z ^ {fb, Q[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE:
                if (Start) state_n = (NumPat == '0) ? S_CHECK : S_RUN;
            S_RUN:
                if (CE && cnt == CNT_W'(1)) state_n = S_CHECK;
            S_CHECK:
                state_n = S_DONE;
            default:
                state_n = S_IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == S_RUN) || (state == S_CHECK);
    end

    always_comb begin
        q_n      = Q;
        cnt_n    = cnt;
        mode_l_n = mode_l;
        done_n   = Done;
        pass_n   = Pass;
        case (state)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    q_n      = SEED;
                    cnt_n    = NumPat;
                    mode_l_n = {B1, B2};
                    done_n   = 1'b0;
                    pass_n   = 1'b0;
                end else if (CE) begin
                    q_n = q_step;
                end
            end
            S_RUN: begin
                if (CE) begin
                    q_n   = q_step;
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_CHECK: begin
                pass_n = (Q == ExpSig);
                done_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Q      <= '0;
            cnt    <= '0;
            mode_l <= 2'b00;
            Done   <= 1'b0;
            Pass   <= 1'b0;
        end else begin
            Q      <= q_n;
            cnt    <= cnt_n;
            mode_l <= mode_l_n;
            Done   <= done_n;
            Pass   <= pass_n;
        end
    end

endmodule

// File: doc/bilbo_bist.md
Name: bilbo_bist

Overview:
- Parametrised next-generation BILBO register with four modes: shift, PRPG, normal and MISR.
- Adds programmable LFSR taps, a reset and a built-in self-test session controller.
- The controller seeds the register, runs a set number of PRPG/MISR steps, compares the final state against an expected signature, and reports Done/Pass.
- Sits between logic blocks under test as a pattern source or response compactor, driven by a test controller.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- TAPS, 8'h1D, feedback tap mask [WIDTH-1:0]; bit i set includes Q[i] in FB. The default is the maximal-length polynomial x^8+x^4+x^3+x^2+1 for WIDTH=8.
- SEED, 8'h01, value loaded into Q at session start; must be nonzero for PRPG.
- CNT_W, 16, width of the pattern counter.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Rst  input  1  synchronous reset, active-high.
- CE  input  1  clock enable for register stepping.
- B1  input  1  mode select MSB.
- B2  input  1  mode select LSB.
- Si  input  1  serial scan in.
- So  output  1  serial scan out, equals Q[0].
- Z  input  WIDTH  parallel data from logic under test.
- Q  output  WIDTH  register contents.
- Start  input  1  one-cycle session start request.
- NumPat  input  CNT_W  number of steps per session, sampled at Start.
- ExpSig  input  WIDTH  expected final Q, sampled in CHECK.
- Busy  output  1  high in RUN and CHECK.
- Done  output  1  session complete.
- Pass  output  1  final Q equalled ExpSig; valid when Done=1.

Behaviour:
- Reset (Rst=1 at edge) overrides everything:
  - Q=0, state=IDLE.
  - Busy=0, Done=0, Pass=0, counter=0.
- Feedback: FB = XOR-reduce(Q & TAPS). Shift direction is right: the new MSB enters Q[WIDTH-1] and Q[0] leaves via So.
- Step function, by mode {B1,B2}, applied only on edges with CE=1:
  - 00 shift: Q <= {Si, Q[WIDTH-1:1]}.
  - 01 PRPG: Q <= {FB, Q[WIDTH-1:1]}.
  - 10 normal: Q <= Z.
  - 11 MISR: Q <= Z ^ {FB, Q[WIDTH-1:1]}.
- State IDLE:
  - Register steps per live {B1,B2} when CE=1.
  - Start=1 (CE ignored): Q <= SEED, counter <= NumPat, latch mode <= {B1,B2}, Done <= 0, Pass <= 0.
  - Next state is RUN, or CHECK if NumPat==0.
- State RUN:
  - Live B1/B2 and Start are ignored; the step uses the latched mode.
  - Each CE=1 edge steps Q and decrements counter. The step with counter==1 moves to CHECK.
  - CE=0 freezes Q, counter and state.
- State CHECK: exactly one cycle, independent of CE.
  - Q holds.
  - Pass <= (Q==ExpSig), Done <= 1, then go to DONE.
- State DONE:
  - Done/Pass hold.
  - Register steps per live {B1,B2} with CE, as in IDLE.
  - Start restarts the session exactly as from IDLE.
- Latency: with Start sampled at edge k and CE held 1, Done=1 is visible after edge k+NumPat+1. Busy is high from after edge k until Done rises.
- Counter is unsigned; NumPat = 2^CNT_W-1 is legal, and there is no wrap.
- A latched mode of 00 or 10 is legal; the session steps that mode anyway.
- Rst mid-session aborts to IDLE with all outputs at reset values.
- Start and Rst in the same cycle: Rst wins.
- A zero state in PRPG stays zero unless the optional feature is compiled in.

Optional Feature:
- Macro BILBO_LOCKUP_GUARD_EN.
- When defined: in PRPG mode (live or latched), a step taken with Q==0 loads SEED instead of the shifted value. MISR and other modes are unaffected.
- When undefined: the all-zero state persists in PRPG.

Test Plan:
- Reset and shift:
  - Rst, then mode 00, CE=1, Si pattern 1,0,1,1 over 4 edges -> Q=8'hD0 and So=0.
  - After 4 more edges with Si=0 -> Q=8'h0D, So=1.
- PRPG period, WIDTH=8, TAPS=8'h1D:
  - Session with mode 01, NumPat=255, ExpSig=8'h01 -> Done after edge k+256, Pass=1.
  - Intermediate values: Q=8'h80 after first step, 8'h40 after second.
- MISR single step:
  - Z=8'h3C, mode 11, NumPat=1, ExpSig=8'hBC -> Pass=1.
  - Repeat with ExpSig=8'hBD -> Pass=0, Done=1.
- NumPat=0:
  - Start with ExpSig=8'h01 -> CHECK directly, Done=1 after edge k+1, Pass=1, Q=8'h01.
- CE gating and mid-session events (mode 01, NumPat=4):
  - Drop CE for 3 cycles mid-RUN -> Q/counter frozen; Done delayed by exactly 3 cycles.
  - Start during RUN is ignored.
  - Rst during RUN -> Q=0, Busy=0, Done=0 next cycle.
- Lockup:
  - Rst, then mode 01, CE=1 -> without BILBO_LOCKUP_GUARD_EN, Q stays 8'h00.
  - With BILBO_LOCKUP_GUARD_EN defined -> Q=8'h01 after first edge, then 8'h80.
